mem_latency_bridge: RTL and testbench
=====================================

Name: mem_latency_bridge

Overview:
- Sits between a zeroriscy core data (or instruction) port and the mem_mod memory model, on the req/gnt/rvalid bus.
- Injects programmable grant and response wait states so core stall handling is exercised under non-ideal memory timing.
- Keeps exactly one transaction outstanding.
- Counts stall cycles seen by the core for fault-tolerance and performance characterisation.

Parameters:
- DW, 3, width of the delay inputs; maximum delay is 2^DW-1 cycles.
- CNT_W, 32, width of the stall counter.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- gnt_delay_i  in  DW  grant wait states; compared live while idle.
- rvalid_delay_i  in  DW  response wait states; latched at upstream grant.
- up_req_i  in  1  core request.
- up_gnt_o  out  1  grant to core; combinational.
- up_rvalid_o  out  1  response valid; registered, one-cycle pulse.
- up_addr_i  in  32  core address.
- up_we_i  in  1  core write enable.
- up_be_i  in  4  core byte enables.
- up_wdata_i  in  32  core write data.
- up_rdata_o  out  32  read data; registered.
- up_err_o  out  1  error flag; valid with up_rvalid_o.
- mem_req_o  out  1  request to memory.
- mem_gnt_i  in  1  memory grant.
- mem_rvalid_i  in  1  memory response valid.
- mem_addr_o  out  32  latched address.
- mem_we_o  out  1  latched write enable.
- mem_be_o  out  4  latched byte enables.
- mem_wdata_o  out  32  latched write data.
- mem_rdata_i  in  32  memory read data.
- mem_err_i  in  1  memory error; tie to 0 for mem_mod.
- stall_cnt_o  out  CNT_W  saturating count of cycles with up_req_i=1 and up_gnt_o=0.

Behaviour:
- Reset (rst_i=1 at a clock edge) produces: state IDLE, all counters 0, up_rvalid_o=0, up_rdata_o=0, up_err_o=0, mem_req_o=0, mem_* latches 0, stall_cnt_o=0.
- Reset mid-transaction abandons the transaction. A mem_rvalid_i that arrives later while IDLE is ignored.
- FSM states: IDLE, MEM_REQ, MEM_WAIT, RESP_WAIT, RESP.
- IDLE:
  - gcnt increments each cycle up_req_i=1 and gcnt!=gnt_delay_i; it clears when up_req_i=0.
  - up_gnt_o = up_req_i & (gcnt==gnt_delay_i). With delay 0 the grant comes in the same cycle as the request.
  - On grant: latch addr/we/be/wdata and rvalid_delay_i, clear gcnt, go to MEM_REQ.
- MEM_REQ:
  - mem_req_o=1 with latched fields.
  - On mem_gnt_i, go to MEM_WAIT.
  - If mem_rvalid_i arrives in the same cycle, treat it as the MEM_WAIT response event.
- MEM_WAIT:
  - On mem_rvalid_i, capture mem_rdata_i and mem_err_i into holding registers.
  - Go to RESP if the latched delay is 0, else go to RESP_WAIT with rcnt=1.
- RESP_WAIT: rcnt increments; go to RESP when rcnt==latched delay.
- RESP:
  - up_rvalid_o=1 for exactly one cycle; up_rdata_o and up_err_o are driven from the holding registers.
  - Go to IDLE.
  - up_rdata_o holds its value until the next response. For writes, up_rdata_o returns the captured memory data unchanged.
- up_gnt_o is 0 in every non-IDLE state. A new request is granted no earlier than the cycle after the RESP cycle.
- Minimum latency with both delays 0 and a mem_mod that grants the same cycle and responds next cycle:
  - grant at T0, mem_req at T1, mem_rvalid at T2, up_rvalid at T3.
  - The general formula is T3 + rvalid_delay_i.
- gnt_delay_i changing while waiting: the comparison uses the live value. If gcnt > new value, gcnt wraps modulo 2^DW until it matches.
- Core dropping up_req_i before grant (protocol violation): gcnt clears; no transaction.
- stall_cnt_o increments when up_req_i & ~up_gnt_o, saturates at all-ones, and clears only on reset.

Decomposition:
- Package mem_bridge_pkg holds the bridge_state_e enum (IDLE, MEM_REQ, MEM_WAIT, RESP_WAIT, RESP) and the default DW/CNT_W localparams.
- One sub-module, bridge_delay_cnt: a DW-bit counter with clear, enable and match output against a target. It is instantiated twice, once as gcnt and once as rcnt.

Test Plan:
- Delays 0/0, read at 0x10 holding 0xDEADBEEF → up_gnt_o in the request cycle, up_rvalid_o exactly 3 cycles later, up_rdata_o=0xDEADBEEF, stall_cnt_o=0.
- gnt_delay_i=3, rvalid_delay_i=2, write 0xCAFEF00D with be=4'b0011 to 0x20 → grant on the 4th request cycle, mem_be_o=0011, up_rvalid_o 5 cycles after grant, stall_cnt_o=3.
- Back-to-back requests with up_req_i held high → second grant no earlier than the cycle after the first up_rvalid_o, and mem_req_o never asserted for two transactions at once.
- Memory holds mem_gnt_i low for 4 cycles in MEM_REQ → mem_req_o and mem_addr_o stay stable; response delayed 4 cycles; up_rvalid_o is a single pulse.
- rst_i asserted in MEM_WAIT, then a stray mem_rvalid_i the next cycle → all outputs 0, state IDLE, no up_rvalid_o.
- Force the stall counter near saturation (CNT_W=4 build) and hold the stall for 20 cycles → stall_cnt_o sticks at 4'hF.

Source files
------------

// File: rtl/mem_bridge_pkg.sv
// Shared types and default sizing for the req/gnt/rvalid latency bridge.
// Holds the bridge FSM state encoding and the default delay/counter widths.
package mem_bridge_pkg;

    localparam int DEF_DW    = 3;
    localparam int DEF_CNT_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        MEM_REQ,
        MEM_WAIT,
        RESP_WAIT,
        RESP
    } bridge_state_e;

endpackage

// File: rtl/bridge_delay_cnt.sv
// Wait-state counter: clears, counts when enabled, flags equality with a live target.
// Latency: match is combinational from the registered count; the count updates one cycle after enable.
// Backpressure: none; the owner decides when to count or clear.
module bridge_delay_cnt
    import mem_bridge_pkg::*;
#(
    parameter int DW = DEF_DW
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clr_i,
    input  logic          en_i,
    input  logic [DW-1:0] target_i,
    output logic          match_o
);

    logic [DW-1:0] cnt_q;

    // Wraps modulo 2^DW, so a target lowered below the count is still reached.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign match_o = (cnt_q == target_i);

endmodule

// File: rtl/mem_latency_bridge.sv
// Single-outstanding req/gnt/rvalid bridge that injects programmable grant and response wait states.
// Latency: grant after gnt_delay_i request cycles; up_rvalid_o arrives 1 + rvalid_delay_i cycles after mem_rvalid_i.
// Backpressure: the core is held off through up_gnt_o until the previous response has been delivered.
module mem_latency_bridge
    import mem_bridge_pkg::*;
#(
    parameter int DW    = DEF_DW,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [DW-1:0]    gnt_delay_i,
    input  logic [DW-1:0]    rvalid_delay_i,
    input  logic             up_req_i,
    output logic             up_gnt_o,
    output logic             up_rvalid_o,
    input  logic [31:0]      up_addr_i,
    input  logic             up_we_i,
    input  logic [3:0]       up_be_i,
    input  logic [31:0]      up_wdata_i,
    output logic [31:0]      up_rdata_o,
    output logic             up_err_o,
    output logic             mem_req_o,
    input  logic             mem_gnt_i,
    input  logic             mem_rvalid_i,
    output logic [31:0]      mem_addr_o,
    output logic             mem_we_o,
    output logic [3:0]       mem_be_o,
    output logic [31:0]      mem_wdata_o,
    input  logic [31:0]      mem_rdata_i,
    input  logic             mem_err_i,
    output logic [CNT_W-1:0] stall_cnt_o
);

    bridge_state_e state_q, state_d;

    logic          gcnt_clr, gcnt_en, gcnt_match;
    logic          rcnt_clr, rcnt_en, rcnt_match;
    logic [DW-1:0] rdly_q;
    logic          rsp_evt;
    logic [31:0]   hold_rdata_q;
    logic          hold_err_q;

    bridge_delay_cnt #(.DW(DW)) u_gcnt (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clr_i    (gcnt_clr),
        .en_i     (gcnt_en),
        .target_i (gnt_delay_i),
        .match_o  (gcnt_match)
    );

    bridge_delay_cnt #(.DW(DW)) u_rcnt (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clr_i    (rcnt_clr),
        .en_i     (rcnt_en),
        .target_i (rdly_q),
        .match_o  (rcnt_match)
    );

    // A response landing together with the memory grant counts as the MEM_WAIT event.
    assign rsp_evt = mem_rvalid_i &&
                     ((state_q == MEM_WAIT) || ((state_q == MEM_REQ) && mem_gnt_i));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        up_gnt_o = 1'b0;
        gcnt_clr = 1'b1;
        gcnt_en  = 1'b0;
        rcnt_clr = 1'b0;
        rcnt_en  = 1'b0;

        case (state_q)
            IDLE: begin
                rcnt_clr = 1'b1;
                if (up_req_i) begin
                    if (gcnt_match) begin
                        up_gnt_o = 1'b1;
                        state_d  = MEM_REQ;
                    end else begin
                        gcnt_clr = 1'b0;
                        gcnt_en  = 1'b1;
                    end
                end
            end
            MEM_REQ, MEM_WAIT: begin
                if (rsp_evt) begin
                    if (rdly_q == '0) begin
                        state_d = RESP;
                    end else begin
                        rcnt_en = 1'b1;
                        state_d = RESP_WAIT;
                    end
                end else if (state_q == MEM_REQ && mem_gnt_i) begin
                    state_d = MEM_WAIT;
                end
            end
            RESP_WAIT: begin
                if (rcnt_match) begin
                    state_d = RESP;
                end else begin
                    rcnt_en = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign mem_req_o = (state_q == MEM_REQ);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_addr_o   <= '0;
            mem_we_o     <= 1'b0;
            mem_be_o     <= '0;
            mem_wdata_o  <= '0;
            rdly_q       <= '0;
            hold_rdata_q <= '0;
            hold_err_q   <= 1'b0;
            up_rvalid_o  <= 1'b0;
            up_rdata_o   <= '0;
            up_err_o     <= 1'b0;
        end else begin
            if (up_gnt_o) begin
                mem_addr_o  <= up_addr_i;
                mem_we_o    <= up_we_i;
                mem_be_o    <= up_be_i;
                mem_wdata_o <= up_wdata_i;
                rdly_q      <= rvalid_delay_i;
            end
            if (rsp_evt) begin
                hold_rdata_q <= mem_rdata_i;
                hold_err_q   <= mem_err_i;
            end
            up_rvalid_o <= (state_d == RESP);
            // With zero response delay the holding register is loaded on the same edge, so bypass it.
            if (state_d == RESP) begin
                up_rdata_o <= rsp_evt ? mem_rdata_i : hold_rdata_q;
                up_err_o   <= rsp_evt ? mem_err_i : hold_err_q;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_o <= '0;
        end else if (up_req_i && !up_gnt_o && (stall_cnt_o != '1)) begin
            stall_cnt_o <= stall_cnt_o + 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_latency_bridge.sv
// Randomized bench for mem_latency_bridge against a transaction-level timing and memory model.
// A second narrow-counter instance exercises stall counter saturation.
module tb_mem_latency_bridge;

    localparam int DW   = 3;
    localparam int NDLY = 1 << DW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [DW-1:0] gnt_delay, rvalid_delay;
    logic          up_req, up_gnt, up_rvalid, up_we, up_err;
    logic [31:0]   up_addr, up_wdata, up_rdata;
    logic [3:0]    up_be, mem_be;
    logic          mem_req, mem_gnt, mem_rvalid, mem_we, mem_err;
    logic [31:0]   mem_addr, mem_wdata, mem_rdata;
    logic [31:0]   stall_cnt;

    logic          s_req, s_gnt, s_rvalid, s_err, s_mreq, s_mwe;
    logic [DW-1:0] s_gdly;
    logic [31:0]   s_rdata, s_maddr, s_mwdata;
    logic [3:0]    s_mbe;
    logic [3:0]    s_stall;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] mem_arr [0:255];
    logic [31:0] ref_arr [0:255];
    logic [31:0] ref_stall;
    logic [31:0] last_rdata;

    mem_latency_bridge #(.DW(DW), .CNT_W(32)) dut (
        .clk_i(clk), .rst_i(rst), .gnt_delay_i(gnt_delay), .rvalid_delay_i(rvalid_delay),
        .up_req_i(up_req), .up_gnt_o(up_gnt), .up_rvalid_o(up_rvalid), .up_addr_i(up_addr),
        .up_we_i(up_we), .up_be_i(up_be), .up_wdata_i(up_wdata), .up_rdata_o(up_rdata),
        .up_err_o(up_err), .mem_req_o(mem_req), .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid),
        .mem_addr_o(mem_addr), .mem_we_o(mem_we), .mem_be_o(mem_be), .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata), .mem_err_i(mem_err), .stall_cnt_o(stall_cnt)
    );

    mem_latency_bridge #(.DW(DW), .CNT_W(4)) dut_sat (
        .clk_i(clk), .rst_i(rst), .gnt_delay_i(s_gdly), .rvalid_delay_i(3'd0),
        .up_req_i(s_req), .up_gnt_o(s_gnt), .up_rvalid_o(s_rvalid), .up_addr_i(32'h0),
        .up_we_i(1'b0), .up_be_i(4'hF), .up_wdata_i(32'h0), .up_rdata_o(s_rdata),
        .up_err_o(s_err), .mem_req_o(s_mreq), .mem_gnt_i(1'b0), .mem_rvalid_i(1'b0),
        .mem_addr_o(s_maddr), .mem_we_o(s_mwe), .mem_be_o(s_mbe), .mem_wdata_o(s_mwdata),
        .mem_rdata_i(32'h0), .mem_err_i(1'b0), .stall_cnt_o(s_stall)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            up_req     = 1'b0;
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b0;
            gnt_delay  = DW'($urandom_range(0, NDLY - 1));
            up_addr    = $urandom;
            #1;
            check_val("idle_gnt", 32'(up_gnt), 32'd0);
            check_val("idle_rvalid", 32'(up_rvalid), 32'd0);
            check_val("idle_mem_req", 32'(mem_req), 32'd0);
            check_val("idle_rdata", up_rdata, last_rdata);
        end
    endtask

    // One core transaction. gd switches to gd2 from cycle chg_at (if >= 0), the memory
    // grants after gw request cycles and responds rl cycles after its grant.
    task automatic run_txn(input logic [31:0] addr, input logic we, input logic [3:0] be,
                           input logic [31:0] wdata, input int gd, input int chg_at, input int gd2,
                           input int rd, input int gw, input int rl, input logic err, input bit hold);
        int          g, r, e, cur;
        logic [31:0] exp_data, resp_word, word;
        logic [7:0]  idx;

        g = -1;
        for (int k = 0; k < 4 * NDLY && g < 0; k++) begin
            cur = (chg_at >= 0 && k >= chg_at) ? gd2 : gd;
            if ((k % NDLY) == cur) g = k;
        end
        r = g + 1 + gw + rl;
        e = r + 1 + rd;

        exp_data = ref_arr[addr[9:2]];
        if (we) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) exp_data[8*b +: 8] = wdata[8*b +: 8];
            ref_arr[addr[9:2]] = exp_data;
        end
        resp_word = 32'h0;

        for (int k = 0; k <= e; k++) begin
            @(negedge clk);
            cur          = (chg_at >= 0 && k >= chg_at) ? gd2 : gd;
            up_req       = (k <= g) || hold;
            gnt_delay    = (k <= g) ? DW'(cur) : DW'($urandom_range(0, NDLY - 1));
            rvalid_delay = (k == g) ? DW'(rd) : DW'($urandom_range(0, NDLY - 1));
            up_addr      = (k <= g) ? addr : $urandom;
            up_we        = (k <= g) ? we : 1'($urandom);
            up_be        = (k <= g) ? be : 4'($urandom);
            up_wdata     = (k <= g) ? wdata : $urandom;
            if (k == g + 1 + gw) begin
                idx  = mem_addr[9:2];
                word = mem_arr[idx];
                if (mem_we)
                    for (int b = 0; b < 4; b++)
                        if (mem_be[b]) word[8*b +: 8] = mem_wdata[8*b +: 8];
                mem_arr[idx] = word;
                resp_word    = word;
            end
            mem_gnt    = (k == g + 1 + gw);
            mem_rvalid = (k == r);
            mem_rdata  = (k == r) ? resp_word : $urandom;
            mem_err    = (k == r) ? err : 1'($urandom);
            #1;
            check_val("up_gnt", 32'(up_gnt), 32'(k == g));
            check_val("mem_req", 32'(mem_req), 32'(k >= g + 1 && k <= g + 1 + gw));
            check_val("up_rvalid", 32'(up_rvalid), 32'(k == e));
            check_val("stall_cnt", stall_cnt, ref_stall);
            if (k >= g + 1 && k <= g + 1 + gw) begin
                check_val("mem_addr", mem_addr, addr);
                check_val("mem_we", 32'(mem_we), 32'(we));
                check_val("mem_be", 32'(mem_be), 32'(be));
                check_val("mem_wdata", mem_wdata, wdata);
            end
            if (k == e) begin
                check_val("up_rdata", up_rdata, exp_data);
                check_val("up_err", 32'(up_err), 32'(err));
                last_rdata = exp_data;
            end else begin
                check_val("rdata_hold", up_rdata, last_rdata);
            end
            if (up_req && k != g) ref_stall++;
        end
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          sat_exp;
        logic [31:0] a, d;
        bit          h;

        rst = 1'b1;
        gnt_delay = '0; rvalid_delay = '0;
        up_req = 1'b0; up_addr = '0; up_we = 1'b0; up_be = '0; up_wdata = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; mem_err = 1'b0;
        s_req = 1'b0; s_gdly = 3'd7;
        for (int i = 0; i < 256; i++) begin
            mem_arr[i] = $urandom;
            ref_arr[i] = mem_arr[i];
        end
        mem_arr[4] = 32'hDEADBEEF;
        ref_arr[4] = 32'hDEADBEEF;
        ref_stall  = 32'd0;
        last_rdata = 32'd0;

        repeat (2) @(negedge clk);
        #1;
        check_val("rst_rvalid", 32'(up_rvalid), 32'd0);
        check_val("rst_rdata", up_rdata, 32'd0);
        check_val("rst_err", 32'(up_err), 32'd0);
        check_val("rst_mem_req", 32'(mem_req), 32'd0);
        check_val("rst_mem_addr", mem_addr, 32'd0);
        check_val("rst_stall", stall_cnt, 32'd0);
        rst = 1'b0;

        run_txn(32'h10, 1'b0, 4'hF, 32'h0, 0, -1, 0, 0, 0, 1, 1'b0, 1'b0);
        idle_cycles(1);
        run_txn(32'h20, 1'b1, 4'b0011, 32'hCAFEF00D, 3, -1, 0, 2, 0, 1, 1'b0, 1'b0);
        idle_cycles(1);
        run_txn(32'h20, 1'b0, 4'hF, 32'h0, 0, -1, 0, 0, 0, 1, 1'b0, 1'b1);
        run_txn(32'h10, 1'b0, 4'hF, 32'h0, 0, -1, 0, 1, 0, 0, 1'b1, 1'b0);
        idle_cycles(2);
        run_txn(32'h30, 1'b1, 4'hF, 32'h12345678, 1, -1, 0, 0, 4, 1, 1'b0, 1'b0);
        idle_cycles(1);
        run_txn(32'h44, 1'b0, 4'hF, 32'h0, 5, 2, 1, 3, 1, 2, 1'b0, 1'b0);
        idle_cycles(1);

        for (int t = 0; t < 40; t++) begin
            a = $urandom;
            d = $urandom;
            h = ($urandom_range(0, 2) == 0);
            run_txn(a, 1'($urandom), 4'($urandom), d,
                    $urandom_range(0, NDLY - 1),
                    ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : -1,
                    $urandom_range(0, NDLY - 1),
                    $urandom_range(0, NDLY - 1), $urandom_range(0, 3), $urandom_range(0, 3),
                    ($urandom_range(0, 3) == 0), h);
            if (!h) idle_cycles($urandom_range(0, 2));
        end
        idle_cycles(1);

        // Abandon a transaction in MEM_WAIT, then offer a stray response.
        @(negedge clk);
        up_req = 1'b1; gnt_delay = '0; rvalid_delay = '0;
        up_addr = 32'h40; up_we = 1'b0; up_be = 4'hF;
        #1;
        check_val("rst_txn_gnt", 32'(up_gnt), 32'd1);
        @(negedge clk);
        up_req = 1'b0; mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0; mem_err = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hA5A5A5A5; mem_err = 1'b1;
        #1;
        check_val("mid_rst_rvalid", 32'(up_rvalid), 32'd0);
        check_val("mid_rst_rdata", up_rdata, 32'd0);
        check_val("mid_rst_err", 32'(up_err), 32'd0);
        check_val("mid_rst_mem_req", 32'(mem_req), 32'd0);
        check_val("mid_rst_mem_addr", mem_addr, 32'd0);
        check_val("mid_rst_mem_be", 32'(mem_be), 32'd0);
        check_val("mid_rst_stall", stall_cnt, 32'd0);
        @(negedge clk);
        mem_rvalid = 1'b0; mem_err = 1'b0;
        #1;
        check_val("stray_rvalid", 32'(up_rvalid), 32'd0);
        check_val("stray_mem_req", 32'(mem_req), 32'd0);
        ref_stall  = 32'd0;
        last_rdata = 32'd0;
        run_txn(32'h10, 1'b0, 4'hF, 32'h0, 0, -1, 0, 0, 0, 1, 1'b0, 1'b0);

        // Narrow counter: memory never grants, so the core stalls every cycle but the grant one.
        sat_exp = 0;
        for (int k = 0; k < 22; k++) begin
            @(negedge clk);
            s_req  = 1'b1;
            s_gdly = 3'd7;
            #1;
            check_val("sat_gnt", 32'(s_gnt), 32'(k == 7));
            check_val("sat_stall", 32'(s_stall), 32'((sat_exp > 15) ? 15 : sat_exp));
            if (k != 7) sat_exp++;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
